// File: rtl/debug_run_ctrl.sv
// Run/step/breakpoint controller driven by command bytes from the UART receiver.
// A byte parser feeds an exec FSM that gates the CPU clock enable and soft reset.
module debug_run_ctrl #(
  parameter int unsigned RST_PULSE_CYCLES = 16,
  parameter int unsigned ARG_TIMEOUT      = 1000000,
  parameter int unsigned STEP_W           = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  input  logic [31:0]       cpu_pc,
  output logic              cpu_ce,
  output logic              sresetn,
  output logic              halted,
  output logic              bp_hit,
  output logic              cmd_err,
  output logic [STEP_W-1:0] step_remaining
);

  localparam int unsigned TimerW = $clog2(ARG_TIMEOUT + 1);
  localparam int unsigned RstW   = $clog2(RST_PULSE_CYCLES + 1);

  localparam logic [7:0] OpRun  = 8'h52;
  localparam logic [7:0] OpHalt = 8'h48;
  localparam logic [7:0] OpStep = 8'h53;
  localparam logic [7:0] OpBrk  = 8'h42;
  localparam logic [7:0] OpClr  = 8'h43;
  localparam logic [7:0] OpZrst = 8'h5A;

  typedef enum logic {StCmd, StArg} parse_state_e;
  typedef enum logic [1:0] {StHalted, StRunning, StStepping, StResetting} exec_state_e;

  parse_state_e      parse_q, parse_d;
  logic [7:0]        op_q, op_d;
  logic [31:0]       arg_q, arg_d;
  logic [2:0]        need_q, need_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              err_q, err_d;

  exec_state_e       exec_q, exec_d;
  logic              skip_q, skip_d;
  logic              bp_hit_q, bp_hit_d;
  logic              bp_valid_q, bp_valid_d;
  logic [31:0]       bp_addr_q, bp_addr_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [RstW-1:0]   rcnt_q, rcnt_d;

  logic              cmd_fire;
  logic [7:0]        cmd_op;
  logic [31:0]       cmd_arg;

  // Parser: a command fires combinationally on its last byte so exec reacts next cycle.
  always_comb begin
    parse_d  = parse_q;
    op_d     = op_q;
    arg_d    = arg_q;
    need_d   = need_q;
    timer_d  = timer_q;
    err_d    = 1'b0;
    cmd_fire = 1'b0;
    cmd_op   = op_q;
    cmd_arg  = '0;
    unique case (parse_q)
      StCmd: begin
        timer_d = '0;
        if (rx_done) begin
          case (rx_data)
            OpRun, OpHalt, OpClr, OpZrst: begin
              cmd_fire = 1'b1;
              cmd_op   = rx_data;
            end
            OpStep: begin
              parse_d = StArg;
              op_d    = rx_data;
              arg_d   = '0;
              need_d  = 3'd2;
            end
            OpBrk: begin
              parse_d = StArg;
              op_d    = rx_data;
              arg_d   = '0;
              need_d  = 3'd4;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      StArg: begin
        if (rx_done) begin
          timer_d = '0;
          arg_d   = {arg_q[23:0], rx_data};
          if (need_q == 3'd1) begin
            cmd_fire = 1'b1;
            cmd_arg  = arg_d;
            parse_d  = StCmd;
          end else begin
            need_d = need_q - 3'd1;
          end
        end else if (timer_q == TimerW'(ARG_TIMEOUT - 1)) begin
          parse_d = StCmd;
          timer_d = '0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: parse_d = StCmd;
    endcase
  end

  logic              cmd_run, cmd_halt, cmd_step, cmd_brk, cmd_clr, cmd_zrst;
  logic [STEP_W-1:0] step_n;
  logic              bp_match;

  assign cmd_run  = cmd_fire && (cmd_op == OpRun);
  assign cmd_halt = cmd_fire && (cmd_op == OpHalt);
  assign cmd_step = cmd_fire && (cmd_op == OpStep);
  assign cmd_brk  = cmd_fire && (cmd_op == OpBrk);
  assign cmd_clr  = cmd_fire && (cmd_op == OpClr);
  assign cmd_zrst = cmd_fire && (cmd_op == OpZrst);
  assign step_n   = STEP_W'(cmd_arg[15:0]);
  // skip_q masks the compare for the first cycle of a run so it can resume from the bp PC.
  assign bp_match = bp_valid_q && !skip_q && (cpu_pc == bp_addr_q);

  always_comb begin
    exec_d     = exec_q;
    skip_d     = skip_q;
    bp_hit_d   = bp_hit_q;
    bp_valid_d = bp_valid_q;
    bp_addr_d  = bp_addr_q;
    rem_d      = rem_q;
    rcnt_d     = rcnt_q;
    cpu_ce     = 1'b0;
    unique case (exec_q)
      StHalted: begin
        if (cmd_run) begin
          exec_d   = StRunning;
          skip_d   = 1'b1;
          bp_hit_d = 1'b0;
        end else if (cmd_step && (step_n != '0)) begin
          exec_d   = StStepping;
          rem_d    = step_n;
          bp_hit_d = 1'b0;
        end else if (cmd_zrst) begin
          exec_d = StResetting;
          rcnt_d = RstW'(RST_PULSE_CYCLES - 1);
        end
      end
      StRunning: begin
        cpu_ce = !bp_match;
        skip_d = 1'b0;
        if (cmd_zrst) begin
          exec_d = StResetting;
          rcnt_d = RstW'(RST_PULSE_CYCLES - 1);
        end else if (bp_match) begin
          exec_d   = StHalted;
          bp_hit_d = 1'b1;
        end else if (cmd_halt) begin
          exec_d = StHalted;
        end
      end
      StStepping: begin
        cpu_ce = 1'b1;
        if (cmd_zrst) begin
          exec_d = StResetting;
          rem_d  = '0;
          rcnt_d = RstW'(RST_PULSE_CYCLES - 1);
        end else if (cmd_halt || (rem_q == STEP_W'(1))) begin
          exec_d = StHalted;
          rem_d  = '0;
        end else begin
          rem_d = rem_q - STEP_W'(1);
        end
      end
      StResetting: begin
        if (rcnt_q == '0) begin
          exec_d = StHalted;
        end else begin
          rcnt_d = rcnt_q - RstW'(1);
        end
      end
      default: exec_d = StHalted;
    endcase
    if (cmd_brk) begin
      bp_valid_d = 1'b1;
      bp_addr_d  = cmd_arg;
    end else if (cmd_clr) begin
      bp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      parse_q    <= StCmd;
      op_q       <= '0;
      arg_q      <= '0;
      need_q     <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      exec_q     <= StHalted;
      skip_q     <= 1'b0;
      bp_hit_q   <= 1'b0;
      bp_valid_q <= 1'b0;
      bp_addr_q  <= '0;
      rem_q      <= '0;
      rcnt_q     <= '0;
    end else begin
      parse_q    <= parse_d;
      op_q       <= op_d;
      arg_q      <= arg_d;
      need_q     <= need_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      exec_q     <= exec_d;
      skip_q     <= skip_d;
      bp_hit_q   <= bp_hit_d;
      bp_valid_q <= bp_valid_d;
      bp_addr_q  <= bp_addr_d;
      rem_q      <= rem_d;
      rcnt_q     <= rcnt_d;
    end
  end

  assign sresetn        = (exec_q != StResetting);
  assign halted         = (exec_q == StHalted);
  assign bp_hit         = bp_hit_q;
  assign cmd_err        = err_q;
  assign step_remaining = rem_q;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Scoreboard bench for debug_run_ctrl: per-cycle expectations are queued when a command
// is sent and checked one entry per cycle on the falling clock edge.
module tb_debug_run_ctrl;

  localparam int unsigned TO = 40;
  localparam int unsigned RP = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [31:0] cpu_pc = 32'h0;
  logic        cpu_ce, sresetn, halted, bp_hit, cmd_err;
  logic [15:0] step_remaining;

  logic        pc_load = 1'b0;
  logic [31:0] pc_load_val = 32'h0;
  logic        ramp_en = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  debug_run_ctrl #(
    .RST_PULSE_CYCLES(RP),
    .ARG_TIMEOUT     (TO),
    .STEP_W          (16)
  ) u_dut (
    .clk           (clk),
    .resetn        (resetn),
    .rx_done       (rx_done),
    .rx_data       (rx_data),
    .cpu_pc        (cpu_pc),
    .cpu_ce        (cpu_ce),
    .sresetn       (sresetn),
    .halted        (halted),
    .bp_hit        (bp_hit),
    .cmd_err       (cmd_err),
    .step_remaining(step_remaining)
  );

  always #5 clk = ~clk;

  // Simple CPU model: PC advances by 4 in every cycle the clock enable is high.
  always @(posedge clk) begin
    if (pc_load) cpu_pc <= pc_load_val;
    else if (ramp_en && cpu_ce) cpu_pc <= cpu_pc + 32'd4;
  end

  typedef struct {
    string tag;
    int    ce;
    int    srst;
    int    hlt;
    int    bp;
    int    rem;
    int    err;
  } exp_t;

  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // -1 in any field means "don't care" for that cycle.
  function automatic void push(input string tag, input int ce, input int srst, input int hlt,
                               input int bp, input int rem, input int err);
    exp_t e;
    e.tag = tag; e.ce = ce; e.srst = srst; e.hlt = hlt; e.bp = bp; e.rem = rem; e.err = err;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.ce   >= 0) check_eq({e.tag, ".cpu_ce"}, 32'(cpu_ce), e.ce);
      if (e.srst >= 0) check_eq({e.tag, ".sresetn"}, 32'(sresetn), e.srst);
      if (e.hlt  >= 0) check_eq({e.tag, ".halted"}, 32'(halted), e.hlt);
      if (e.bp   >= 0) check_eq({e.tag, ".bp_hit"}, 32'(bp_hit), e.bp);
      if (e.rem  >= 0) check_eq({e.tag, ".step_rem"}, 32'(step_remaining), e.rem);
      if (e.err  >= 0) check_eq({e.tag, ".cmd_err"}, 32'(cmd_err), e.err);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_done = 1'b1;
    rx_data = b;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    @(posedge clk); #1;
    pc_load_val = v;
    pc_load = 1'b1;
    @(posedge clk); #1;
    pc_load = 1'b0;
  endtask

  task automatic wait_sb(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check_eq({tag, ".sb_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check_eq("rst.cpu_ce", 32'(cpu_ce), 32'd0);
    check_eq("rst.sresetn", 32'(sresetn), 32'd1);
    check_eq("rst.halted", 32'(halted), 32'd1);
    check_eq("rst.bp_hit", 32'(bp_hit), 32'd0);
    check_eq("rst.cmd_err", 32'(cmd_err), 32'd0);
    check_eq("rst.step_rem", 32'(step_remaining), 32'd0);

    // Step 5: exactly five enabled cycles, then halted.
    send_byte(8'h53); send_byte(8'h00); send_byte(8'h05);
    for (int i = 0; i < 5; i++) push("step5", 1, 1, 0, -1, 5 - i, 0);
    push("step5_end", 0, 1, 1, -1, 0, 0);
    wait_sb("step5");

    // Step 0 is a no-op.
    send_byte(8'h53); send_byte(8'h00); send_byte(8'h00);
    push("step0", 0, 1, 1, -1, 0, 0);
    push("step0", 0, 1, 1, -1, 0, 0);
    wait_sb("step0");

    // Breakpoint at 0x40, run from 0x30.
    set_pc(32'h30);
    ramp_en = 1'b1;
    send_byte(8'h42); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40);
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) push("bp_run", 1, 1, 0, 0, -1, -1);
    push("bp_match", 0, 1, 0, 0, -1, -1);
    push("bp_halt", 0, 1, 1, 1, -1, -1);
    wait_sb("bp");
    check_eq("bp.pc", cpu_pc, 32'h40);

    // Resume from the breakpoint PC.
    send_byte(8'h52);
    push("resume0", 1, 1, 0, 0, -1, -1);
    push("resume1", 1, 1, 0, 0, -1, -1);
    wait_sb("resume");

    // Soft reset while running.
    send_byte(8'h5A);
    for (int i = 0; i < int'(RP); i++) push("zrst", 0, 0, 0, -1, 0, -1);
    push("zrst_end", 0, 1, 1, -1, 0, -1);
    wait_sb("zrst");

    // Breakpoint kept across soft reset.
    set_pc(32'h3C);
    send_byte(8'h52);
    push("bpkeep_run", 1, 1, 0, 0, -1, -1);
    push("bpkeep_match", 0, 1, 0, 0, -1, -1);
    push("bpkeep_halt", 0, 1, 1, 1, -1, -1);
    wait_sb("bpkeep");

    // Long step aborted by halt.
    send_byte(8'h53); send_byte(8'hFF); send_byte(8'hFF);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("longstep.rem", 32'(step_remaining), 32'hFFF5);
    check_eq("longstep.ce", 32'(cpu_ce), 32'd1);
    send_byte(8'h48);
    push("longstep_halt", 0, 1, 1, 0, 0, -1);
    wait_sb("longstep");

    // Unknown opcode.
    send_byte(8'h77);
    push("badop", 0, 1, 1, -1, -1, 1);
    push("badop_end", 0, 1, 1, -1, -1, 0);
    wait_sb("badop");

    // Argument timeout, then the parser must accept a fresh command.
    send_byte(8'h53); send_byte(8'h00);
    for (int i = 0; i < int'(TO); i++) push("argto_wait", 0, 1, 1, -1, 0, 0);
    push("argto_err", 0, 1, 1, -1, 0, 1);
    push("argto_end", 0, 1, 1, -1, 0, 0);
    wait_sb("argto");
    send_byte(8'h53); send_byte(8'h00); send_byte(8'h02);
    push("after_to", 1, 1, 0, -1, 2, 0);
    push("after_to", 1, 1, 0, -1, 1, 0);
    push("after_to_end", 0, 1, 1, -1, 0, 0);
    wait_sb("after_to");

    // Hard reset mid-burst clears state and the breakpoint.
    send_byte(8'h53); send_byte(8'h00); send_byte(8'h20);
    repeat (3) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check_eq("hrst.halted", 32'(halted), 32'd1);
    check_eq("hrst.cpu_ce", 32'(cpu_ce), 32'd0);
    check_eq("hrst.step_rem", 32'(step_remaining), 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    set_pc(32'h3C);
    send_byte(8'h52);
    push("hrst_run", 1, 1, 0, 0, -1, -1);
    push("hrst_nobp", 1, 1, 0, 0, -1, -1);
    wait_sb("hrst");
    check_eq("hrst.pc", cpu_pc, 32'h48);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
